period_meter: RTL and testbench

- Inverse of the team's clock divider: measures the period of a slow incoming square wave in cycles of the fast system clock.
- Typical use: verify the 1 kHz divided clock against the 10 MHz system clock (expected period 10000 cycles). Also checks external slow signals.
- Sits beside the divider; its outputs feed status/display logic.

---
 rtl/period_meter_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/period_meter.sv | 128 ++++++++++++
 tb/tb_period_meter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int DEF_COUNT_W  = 16;
    localparam int DEF_EXPECTED = 10000;
    localparam int DEF_TOL      = 50;
    localparam int DEF_LOCK_N   = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a one-cycle
// rising-edge pulse; usable for any slow asynchronous signal.
module sync_edge_detect
    import period_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 & ~r_hist;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in inClock cycles.
// Optional lock indicator is built only when PERIOD_METER_LOCK_EN is defined.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNT_W  = DEF_COUNT_W,
    parameter int EXPECTED = DEF_EXPECTED,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_N   = DEF_LOCK_N
) (
    input  logic               inClock,
    input  logic               reset,
    input  logic               sigIn,
    input  logic               enable,
    output logic [COUNT_W-1:0] period,
    output logic               periodValid,
    output logic               overflow,
    output logic               locked
);

    localparam logic [COUNT_W-1:0] MAX_CNT = '1;

    logic               w_edge;
    state_t             r_state;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_period;
    logic               r_valid;
    logic               r_ovf;

    sync_edge_detect u_sync (
        .clk     (inClock),
        .rst     (reset),
        .i_async (sigIn),
        .o_edge  (w_edge)
    );

    always_ff @(posedge inClock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_count <= '0;
                        r_state <= ARM;
                    end
                    ARM: begin
                        if (w_edge) begin
                            r_count <= COUNT_W'(1);
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // An edge coinciding with a full counter still reports max.
                        if (w_edge) begin
                            r_period <= r_count;
                            r_valid  <= 1'b1;
                            r_count  <= COUNT_W'(1);
                        end else if (r_count == MAX_CNT) begin
                            r_ovf   <= 1'b1;
                            r_count <= '0;
                            r_state <= ARM;
                        end else begin
                            r_count <= r_count + COUNT_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period      = r_period;
    assign periodValid = r_valid;
    assign overflow    = r_ovf;

`ifdef PERIOD_METER_LOCK_EN
    localparam int          LCNT_W = $clog2(LOCK_N + 1);
    localparam logic [63:0] WIN_LO = (EXPECTED > TOL) ? 64'(EXPECTED - TOL) : 64'd0;
    localparam logic [63:0] WIN_HI = 64'(EXPECTED + TOL);

    logic [LCNT_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic [63:0]       w_cnt_ext;
    logic              w_in_win;

    assign w_cnt_ext = 64'(r_count);
    assign w_in_win  = (w_cnt_ext >= WIN_LO) && (w_cnt_ext <= WIN_HI);

    // Judged on the counter value that is being latched into period.
    always_ff @(posedge inClock) begin
        if (reset || !enable) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (r_state == MEASURE) begin
            if (w_edge) begin
                if (w_in_win) begin
                    if (r_lock_cnt != LCNT_W'(LOCK_N))
                        r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
                    r_locked <= (r_lock_cnt >= LCNT_W'(LOCK_N - 1));
                end else begin
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            end else if (r_count == MAX_CNT) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end
        end
    end

    assign locked = r_locked;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(EXPECTED), 32'(TOL), 32'(LOCK_N)};
    assign locked       = 1'b0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance for period/lock/enable
// behaviour and an 8-bit instance for overflow and the full-count corner.
module tb_period_meter;

`ifdef PERIOD_METER_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en16, sig16, en8, sig8;
    logic [15:0] per16;
    logic        pv16, ovf16, lock16;
    logic [7:0]  per8;
    logic        pv8, ovf8, lock8;

    period_meter #(.COUNT_W(16), .EXPECTED(10000), .TOL(50), .LOCK_N(4)) dut16 (
        .inClock(clk), .reset(rst), .sigIn(sig16), .enable(en16),
        .period(per16), .periodValid(pv16), .overflow(ovf16), .locked(lock16)
    );

    period_meter #(.COUNT_W(8), .EXPECTED(10000), .TOL(50), .LOCK_N(4)) dut8 (
        .inClock(clk), .reset(rst), .sigIn(sig8), .enable(en8),
        .period(per8), .periodValid(pv8), .overflow(ovf8), .locked(lock8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q16_per[$];
    int q16_cyc[$];
    int q16_lock[$];
    int q8_per[$];

    always @(negedge clk) begin
        if (pv16) begin
            q16_per.push_back(int'(per16));
            q16_cyc.push_back(cyc);
            q16_lock.push_back(int'(lock16));
        end
        if (pv8) q8_per.push_back(int'(per8));
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_per;
        bit exp_lock;
    } vec_t;

    vec_t tbl[5];
    int   rise_cyc[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, c0, dt;
        bit found;

        tbl[0] = '{5000, 5000, 10000, 1'b0};
        tbl[1] = '{5000, 5000, 10000, 1'b0};
        tbl[2] = '{5010, 5010, 10020, 1'b0};
        tbl[3] = '{5010, 5010, 10020, LOCK_ON};
        tbl[4] = '{5050, 5050, 10100, 1'b0};

        rst = 1'b1; en16 = 1'b0; sig16 = 1'b0; en8 = 1'b0; sig8 = 1'b0;
        tick(5);
        rst = 1'b0; en16 = 1'b1;
        tick(1);
        chk("reset_period",   int'(per16),  0);
        chk("reset_valid",    int'(pv16),   0);
        chk("reset_overflow", int'(ovf16),  0);
        chk("reset_locked",   int'(lock16), 0);
        chk("reset_ovf8",     int'(ovf8),   0);
        tick(5);

        // Square waves from the table; the first rise only arms the meter.
        for (int i = 0; i < 5; i++) begin
            rise_cyc[i] = cyc;
            sig16 = 1'b1; tick(tbl[i].hi);
            sig16 = 1'b0; tick(tbl[i].lo);
        end
        rise_cyc[5] = cyc;
        sig16 = 1'b1; tick(10);

        chk("report_count", q16_per.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("period[%0d]", i),
                (i < q16_per.size()) ? q16_per[i] : -1, tbl[i].exp_per);
            chk($sformatf("locked[%0d]", i),
                (i < q16_lock.size()) ? q16_lock[i] : -1, int'(tbl[i].exp_lock));
            if (i == 0)
                chk("first_latency", (q16_cyc.size() > 0) ? q16_cyc[0] - rise_cyc[1] : -1, 3);
            else
                chk($sformatf("spacing[%0d]", i),
                    (i < q16_cyc.size()) ? q16_cyc[i] - q16_cyc[i-1] : -1, tbl[i].exp_per);
        end

        // Enable dropped mid-period, then two fresh edges.
        tick(40); sig16 = 1'b0; tick(20);
        n0 = q16_per.size();
        en16 = 1'b0; tick(3);
        chk("en0_period_hold", int'(per16),  10100);
        chk("en0_overflow",    int'(ovf16),  0);
        chk("en0_locked",      int'(lock16), 0);
        en16 = 1'b1; tick(30);
        sig16 = 1'b1; tick(50); sig16 = 1'b0; tick(50);
        chk("rearm_no_report", q16_per.size(), n0);
        chk("rearm_period_hold", int'(per16), 10100);
        sig16 = 1'b1; tick(50); sig16 = 1'b0; tick(50);
        chk("rearm_report", q16_per.size(), n0 + 1);
        chk("rearm_period", int'(per16), 100);

        // Minimum period: sigIn toggles every cycle.
        n1 = q16_per.size();
        repeat (10) begin
            sig16 = 1'b1; tick(1);
            sig16 = 1'b0; tick(1);
        end
        tick(6);
        chk("p2_count", q16_per.size(), n1 + 10);
        chk("p2_first", (n1 < q16_per.size()) ? q16_per[n1] : -1, 100);
        for (int k = 1; k < 10; k++) begin
            chk($sformatf("p2_period[%0d]", k),
                (n1 + k < q16_per.size()) ? q16_per[n1+k] : -1, 2);
            chk($sformatf("p2_spacing[%0d]", k),
                (n1 + k < q16_cyc.size()) ? q16_cyc[n1+k] - q16_cyc[n1+k-1] : -1, 2);
        end

        // 8-bit instance: one edge, then silence until overflow.
        en8 = 1'b1; tick(3);
        c0 = cyc;
        sig8 = 1'b1; tick(10); sig8 = 1'b0;
        found = 1'b0; dt = -1;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (ovf8) begin
                found = 1'b1;
                dt = cyc - c0;
            end
        end
        chk("ovf_latency", dt, 258);
        chk("ovf_no_report", q8_per.size(), 0);
        chk("ovf_period_hold", int'(per8), 0);

        // Back in ARM: period 100 measured, overflow stays sticky.
        sig8 = 1'b1; tick(50); sig8 = 1'b0; tick(50);
        chk("ovf_rearm_no_report", q8_per.size(), 0);
        sig8 = 1'b1; tick(50); sig8 = 1'b0; tick(50);
        chk("ovf_p100_count", q8_per.size(), 1);
        chk("ovf_p100_period", int'(per8), 100);
        chk("ovf_sticky", int'(ovf8), 1);

        // Edge arriving exactly at full count reports max.
        tick(155);
        sig8 = 1'b1; tick(10); sig8 = 1'b0; tick(10);
        chk("max_count", q8_per.size(), 2);
        chk("max_period", int'(per8), 255);
        chk("max_ovf_unchanged", int'(ovf8), 1);

        en8 = 1'b0; tick(2);
        chk("en0_ovf_clear", int'(ovf8), 0);
        chk("en0_per8_hold", int'(per8), 255);
        chk("locked8", int'(lock8), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
